// File: rtl/fetch_receive_pkg.sv
// Encodings shared by fetch_issue, fetch_receive and the control unit.
package fetch_receive_pkg;

    localparam logic [1:0] PC_INCR    = 2'b00;
    localparam logic [1:0] PC_STALL   = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;
    localparam logic [1:0] PC_RESTART = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        RUN        = 2'd1,
        HOLD       = 2'd2,
        SQUASH     = 2'd3
    } fr_state_t;

    // A flush is treated exactly like a redirect; it outranks a stall.
    function automatic fr_state_t decode_select(input logic flush, input logic [1:0] sel);
        fr_state_t s;
        if (flush || sel[1])
            s = SQUASH;
        else if (sel == PC_STALL)
            s = HOLD;
        else
            s = RUN;
        return s;
    endfunction

endpackage

// File: rtl/fetch_receive.sv
// Fetch receive stage: aligns I-cache read data with its PC and drives decode.
// State | meaning
//   RESET_WAIT | first cycle after reset, memory data not yet meaningful
//   RUN        | pass through cache data with the PC issued last cycle
//   HOLD       | repeat last cycle's outputs (stall)
//   SQUASH     | wrong-path slot replaced by an invalid NOP
module fetch_receive
    import fetch_receive_pkg::*;
#(
    parameter int                    CORE            = 0,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDRESS_BITS    = 20,
    parameter logic [DATA_WIDTH-1:0] NOP             = NOP_INST,
    parameter int                    SCAN_CYCLES_MIN = 1,
    parameter int                    SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              next_PC_select,
    input  logic                    flush,
    input  logic [ADDRESS_BITS-1:0] issue_PC,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    inst_valid,
    input  logic                    scan
);

    fr_state_t                 state;
    fr_state_t                 state_next;
    logic [ADDRESS_BITS-1:0]   pc_pipe;
    logic [2:0]                sel_q;
    logic [DATA_WIDTH-1:0]     hold_inst;
    logic [ADDRESS_BITS-1:0]   hold_PC;
    logic                      hold_valid;
    logic [31:0]               cycle_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RESET_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = decode_select(flush, next_PC_select);
    end

    always_comb begin
        instruction = NOP;
        inst_PC     = '0;
        inst_valid  = 1'b0;
        unique case (state)
            RESET_WAIT: begin
                instruction = NOP;
                inst_PC     = '0;
                inst_valid  = 1'b0;
            end
            RUN: begin
                instruction = i_mem_data;
                inst_PC     = pc_pipe;
                inst_valid  = 1'b1;
            end
            HOLD: begin
                instruction = hold_inst;
                inst_PC     = hold_PC;
                inst_valid  = hold_valid;
            end
            SQUASH: begin
                instruction = NOP;
                inst_PC     = pc_pipe;
                inst_valid  = 1'b0;
            end
            default: begin
                instruction = NOP;
                inst_PC     = '0;
                inst_valid  = 1'b0;
            end
        endcase
    end

    // Hold registers always capture the visible outputs so a stall repeats them exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_pipe     <= '0;
            sel_q       <= {1'b0, PC_STALL};
            hold_inst   <= NOP;
            hold_PC     <= '0;
            hold_valid  <= 1'b0;
            cycle_count <= '0;
        end else begin
            pc_pipe     <= issue_PC;
            sel_q       <= {flush, next_PC_select};
            hold_inst   <= instruction;
            hold_PC     <= inst_PC;
            hold_valid  <= inst_valid;
            cycle_count <= cycle_count + 32'd1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (scan && (cycle_count >= 32'(SCAN_CYCLES_MIN)) && (cycle_count <= 32'(SCAN_CYCLES_MAX))) begin
            $display("core %0d fetch_receive cyc=%0d state=%s sel_q=%b inst=%h pc=%h valid=%b",
                     CORE, cycle_count, state.name(), sel_q, instruction, inst_PC, inst_valid);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_receive.sv
// Directed bench for fetch_receive with a cycle-level reference model.
module tb_fetch_receive;
    import fetch_receive_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  next_PC_select;
    logic        flush;
    logic [19:0] issue_PC;
    logic [31:0] i_mem_data;
    logic [31:0] instruction;
    logic [19:0] inst_PC;
    logic        inst_valid;
    logic        scan;

    int checks   = 0;
    int failures = 0;

    fetch_receive dut (
        .clock          (clock),
        .reset          (reset),
        .next_PC_select (next_PC_select),
        .flush          (flush),
        .issue_PC       (issue_PC),
        .i_mem_data     (i_mem_data),
        .instruction    (instruction),
        .inst_PC        (inst_PC),
        .inst_valid     (inst_valid),
        .scan           (scan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: remembers what happened at the last edge and what decode saw last cycle.
    logic        m_started;
    logic [1:0]  m_sel;
    logic        m_flush;
    logic [19:0] m_pc;
    logic [31:0] m_last_inst;
    logic [19:0] m_last_pc;
    logic        m_last_valid;
    logic [31:0] e_inst;
    logic [19:0] e_pc;
    logic        e_valid;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_started    <= 1'b0;
            m_sel        <= PC_STALL;
            m_flush      <= 1'b0;
            m_pc         <= '0;
            m_last_inst  <= NOP_INST;
            m_last_pc    <= '0;
            m_last_valid <= 1'b0;
        end else begin
            m_started    <= 1'b1;
            m_sel        <= next_PC_select;
            m_flush      <= flush;
            m_pc         <= issue_PC;
            m_last_inst  <= e_inst;
            m_last_pc    <= e_pc;
            m_last_valid <= e_valid;
        end
    end

    always @(negedge clock) begin
        if (!m_started) begin
            e_inst = NOP_INST; e_pc = '0; e_valid = 1'b0;
        end else if (m_flush || m_sel == PC_JUMP || m_sel == PC_RESTART) begin
            e_inst = NOP_INST; e_pc = m_pc; e_valid = 1'b0;
        end else if (m_sel == PC_STALL) begin
            e_inst = m_last_inst; e_pc = m_last_pc; e_valid = m_last_valid;
        end else begin
            e_inst = i_mem_data; e_pc = m_pc; e_valid = 1'b1;
        end
        checks++;
        if (instruction !== e_inst || inst_PC !== e_pc || inst_valid !== e_valid) begin
            failures++;
            $display("FAIL model t=%0t got inst=%h pc=%h v=%b expected inst=%h pc=%h v=%b",
                     $time, instruction, inst_PC, inst_valid, e_inst, e_pc, e_valid);
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic        fl;
        logic [19:0] pc;
        logic [31:0] mem;
        logic [31:0] ei;
        logic [19:0] ep;
        logic        ev;
    } vec_t;

    vec_t vecs[31];

    task automatic apply(input int i);
        next_PC_select = vecs[i].sel;
        flush          = vecs[i].fl;
        issue_PC       = vecs[i].pc;
        i_mem_data     = vecs[i].mem;
    endtask

    task automatic check_lit(input int i);
        checks++;
        if (instruction !== vecs[i].ei || inst_PC !== vecs[i].ep || inst_valid !== vecs[i].ev) begin
            failures++;
            $display("FAIL vec%0d got inst=%h pc=%h v=%b expected inst=%h pc=%h v=%b",
                     i, instruction, inst_PC, inst_valid, vecs[i].ei, vecs[i].ep, vecs[i].ev);
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 20'h00000, 32'hDEADBEEF, NOP_INST,     20'h00000, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 20'h00004, 32'h000000A0, 32'h000000A0, 20'h00000, 1'b1};
        vecs[2]  = '{2'b01, 1'b0, 20'h00008, 32'h000000A4, 32'h000000A4, 20'h00004, 1'b1};
        vecs[3]  = '{2'b01, 1'b0, 20'h00008, 32'h000000FF, 32'h000000A4, 20'h00004, 1'b1};
        vecs[4]  = '{2'b01, 1'b0, 20'h00008, 32'h000000FF, 32'h000000A4, 20'h00004, 1'b1};
        vecs[5]  = '{2'b00, 1'b0, 20'h00008, 32'h000000FF, 32'h000000A4, 20'h00004, 1'b1};
        vecs[6]  = '{2'b10, 1'b0, 20'h0000C, 32'h000000A8, 32'h000000A8, 20'h00008, 1'b1};
        vecs[7]  = '{2'b00, 1'b0, 20'h00100, 32'h000000AC, NOP_INST,     20'h0000C, 1'b0};
        vecs[8]  = '{2'b00, 1'b0, 20'h00104, 32'h0000B100, 32'h0000B100, 20'h00100, 1'b1};
        vecs[9]  = '{2'b10, 1'b0, 20'h00108, 32'h0000B104, 32'h0000B104, 20'h00104, 1'b1};
        vecs[10] = '{2'b01, 1'b0, 20'h00100, 32'h0000B108, NOP_INST,     20'h00108, 1'b0};
        vecs[11] = '{2'b01, 1'b0, 20'h00100, 32'h0000B100, NOP_INST,     20'h00108, 1'b0};
        vecs[12] = '{2'b00, 1'b0, 20'h00100, 32'h0000B100, NOP_INST,     20'h00108, 1'b0};
        vecs[13] = '{2'b00, 1'b0, 20'h00104, 32'h0000B100, 32'h0000B100, 20'h00100, 1'b1};
        vecs[14] = '{2'b01, 1'b1, 20'h00108, 32'h0000B104, 32'h0000B104, 20'h00104, 1'b1};
        vecs[15] = '{2'b00, 1'b0, 20'h00200, 32'h0000B108, NOP_INST,     20'h00108, 1'b0};
        vecs[16] = '{2'b11, 1'b0, 20'h00204, 32'h0000C200, 32'h0000C200, 20'h00200, 1'b1};
        vecs[17] = '{2'b00, 1'b0, 20'h00000, 32'h0000C204, NOP_INST,     20'h00204, 1'b0};
        vecs[18] = '{2'b00, 1'b0, 20'h00004, 32'h000000A0, 32'h000000A0, 20'h00000, 1'b1};
        vecs[19] = '{2'b01, 1'b0, 20'h00008, 32'h000000A4, 32'h000000A4, 20'h00004, 1'b1};
        vecs[20] = '{2'b10, 1'b0, 20'h00008, 32'h00000077, 32'h000000A4, 20'h00004, 1'b1};
        vecs[21] = '{2'b10, 1'b0, 20'h00300, 32'h00000088, NOP_INST,     20'h00008, 1'b0};
        vecs[22] = '{2'b00, 1'b0, 20'h00400, 32'h00000099, NOP_INST,     20'h00300, 1'b0};
        vecs[23] = '{2'b01, 1'b0, 20'h00404, 32'h0000D400, 32'h0000D400, 20'h00400, 1'b1};
        vecs[24] = '{2'b01, 1'b0, 20'h00404, 32'h00000055, 32'h0000D400, 20'h00400, 1'b1};
        vecs[25] = '{2'b01, 1'b0, 20'h00404, 32'h00000055, 32'h0000D400, 20'h00400, 1'b1};
        vecs[26] = '{2'b00, 1'b0, 20'h00000, 32'h00000066, NOP_INST,     20'h00000, 1'b0};
        vecs[27] = '{2'b00, 1'b0, 20'h00004, 32'h000000A0, 32'h000000A0, 20'h00000, 1'b1};
        vecs[28] = '{2'b00, 1'b0, 20'hFFFFC, 32'h000000A4, 32'h000000A4, 20'h00004, 1'b1};
        vecs[29] = '{2'b00, 1'b0, 20'h00000, 32'h000000E0, 32'h000000E0, 20'hFFFFC, 1'b1};
        vecs[30] = '{2'b00, 1'b0, 20'h00004, 32'h000000A0, 32'h000000A0, 20'h00000, 1'b1};

        reset = 1'b0;
        scan  = 1'b0;
        next_PC_select = PC_INCR;
        flush = 1'b0;
        issue_PC = '0;
        i_mem_data = '0;
        #1 reset = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        apply(0);
        @(negedge clock);
        check_lit(0);
        for (int i = 1; i <= 25; i++) begin
            @(posedge clock);
            #1;
            apply(i);
            @(negedge clock);
            check_lit(i);
        end

        // Reset lands mid-HOLD, between edges; outputs must clear at once.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (instruction !== NOP_INST) begin
            failures++;
            $display("FAIL async_reset_inst got %h expected %h", instruction, NOP_INST);
        end
        checks++;
        if (inst_PC !== 20'h0) begin
            failures++;
            $display("FAIL async_reset_pc got %h expected 0", inst_PC);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_valid got %b expected 0", inst_valid);
        end

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        apply(26);
        @(negedge clock);
        check_lit(26);
        for (int i = 27; i <= 30; i++) begin
            @(posedge clock);
            #1;
            apply(i);
            @(negedge clock);
            check_lit(i);
        end

        @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_receive.md
Name: fetch_receive

Overview:
- Receive side of the fetch stage: consumes the synchronous I-cache read data addressed by fetch_issue one cycle earlier.
- Presents an aligned instruction, its PC and a valid flag to decode.
- Honours the same next_PC_select encoding so stalls hold the delivered instruction and redirects squash the wrong-path slot.
- Sits between the instruction cache read port and the decode stage.

Parameters:
CORE, 0, core index used only in scan printouts
DATA_WIDTH, 32, instruction width
ADDRESS_BITS, 20, PC width
NOP, 32'h00000013, instruction driven on squashed/idle slots (addi x0,x0,0)
SCAN_CYCLES_MIN, 1, first cycle count at which scan printout is enabled
SCAN_CYCLES_MAX, 1000, last cycle count at which scan printout is enabled

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
next_PC_select  input  2  same encoding as fetch_issue: 00 increment, 01 stall, 10 redirect, 11 restart at 0
flush  input  1  squash request from later stages (exception/trap); same effect as a redirect
issue_PC  input  ADDRESS_BITS  PC presented to the I-cache this cycle
i_mem_data  input  DATA_WIDTH  I-cache read data for the address presented in the previous cycle
instruction  output  DATA_WIDTH  instruction to decode
inst_PC  output  ADDRESS_BITS  PC of instruction
inst_valid  output  1  instruction is architecturally valid
scan  input  1  enables debug printout

Behaviour:
- Registered state:
  - pc_pipe <= issue_PC every cycle.
  - sel_q <= {flush, next_PC_select}, with flush decoded as a squash.
  - hold_inst, hold_PC, hold_valid <= current outputs every cycle.
  - state register; cycle counter for scan.
- States, derived from the event registered in cycle t and applied in cycle t+1:
  - RESET_WAIT: one cycle after reset deassertion; memory data is not yet meaningful; output NOP, inst_PC 0, inst_valid 0.
  - RUN: previous select 00; instruction = i_mem_data, inst_PC = pc_pipe, inst_valid = 1; all combinational from i_mem_data.
  - HOLD: previous select 01; instruction/inst_PC/inst_valid = hold registers, i.e. an exact repeat of the previous cycle's outputs, including a held NOP/invalid.
  - SQUASH: previous select 10 or 11, or flush; output NOP, inst_PC = pc_pipe, inst_valid 0.
- Transitions, evaluated every clock from any state:
  - flush or select 1x -> SQUASH.
  - else 01 -> HOLD.
  - else 00 -> RUN.
  - RESET_WAIT is always left after exactly one cycle by the same rule.
- Priority: reset > flush > redirect/restart (1x) > stall (01) > increment (00).
- Latency: an address issued in cycle t appears on instruction in cycle t+1 unless squashed; there are no bubbles in RUN.
- Reset (asynchronous, any time, including mid-HOLD or mid-SQUASH):
  - state = RESET_WAIT; hold_inst = NOP; hold_valid = 0; hold_PC = 0; pc_pipe = 0; sel_q = 01; cycle counter = 0.
  - Outputs immediately: NOP / 0 / 0.
- Boundary cases:
  - Stall immediately after redirect: NOP held invalid; the target instruction appears the cycle after the stall releases.
  - Redirect during HOLD: the next cycle is SQUASH; held content is discarded.
  - Back-to-back redirects: every slot is squashed until a 00 or 01 follows a redirect.
  - Flush coincident with stall: flush wins.
  - Multi-cycle stall: outputs stable for all stall cycles, and the held instruction is independent of i_mem_data changes.
  - pc_pipe wraps naturally at 2^ADDRESS_BITS; no special handling.
- Scan:
  - Active only when scan=1 and SCAN_CYCLES_MIN <= cycle counter <= SCAN_CYCLES_MAX.
  - Prints CORE, state, instruction, inst_PC, inst_valid.
  - Simulation-only; no effect on outputs.

Decomposition:
- Shared package contents:
  - next_PC_select encodings (PC_INCR 2'b00, PC_STALL 2'b01, PC_JUMP 2'b10, PC_RESTART 2'b11).
  - NOP constant.
  - fetch_receive state encoding (RESET_WAIT, RUN, HOLD, SQUASH).
- The encodings are shared with fetch_issue and the control unit.
- No sub-module is natural: the block is one state register plus a three-way output mux and hold registers.

Test Plan:
- Reset release, then select 00 with issue_PC 0,4,8 and memory returning 0xA0,0xA4,0xA8 -> first output cycle NOP/valid 0; then 0xA0@0, 0xA4@4, 0xA8@8, all valid 1.
- Stall of 3 cycles while outputting 0xA4@4, with i_mem_data changing to 0xFF -> output stays 0xA4@4 valid for 3 cycles; 0xA8@8 appears the cycle after release.
- Redirect to 0x100 while issuing 0x0C -> next cycle NOP, valid 0; following cycle the instruction at 0x100 is output with inst_PC 0x100, valid 1.
- Redirect followed by a 2-cycle stall -> NOP/invalid for 3 cycles, then the 0x100 instruction valid.
- flush and stall asserted together -> next cycle NOP/invalid (flush priority); select 11 -> squash, then PC 0 instruction.
- Reset asserted asynchronously mid-HOLD -> outputs go to NOP/0/0 without waiting for a clock edge; after release, one RESET_WAIT cycle, then normal RUN.
